ex_alu_arbiter: RTL and testbench
=================================

EX_ALU_ARBITER -- requirements
Module: ex_alu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width.
REQ-002 SHALL have parameter RESET_PRIO, default 0: port holding round-robin priority after reset.
REQ-003 SHALL have clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have resetn  input  1: asynchronous, active-low reset.
REQ-005 SHALL have p0_valid, p1_valid  input  1 each: request present on port n.
REQ-006 SHALL have p0_ready, p1_ready  output  1 each: request on port n accepted this cycle.
REQ-007 SHALL have p0_op, p1_op  input  4 each: ALU opcode for port n.
REQ-008 SHALL have p0_a, p0_b, p1_a, p1_b  input  XLEN each: operands for port n.
REQ-009 SHALL have r0_valid, r1_valid  output  1 each: result held for port n.
REQ-010 SHALL have r0_ready, r1_ready  input  1 each: port n consumes its result.
REQ-011 SHALL have r0_result, r1_result  output  XLEN each: registered result for port n.
REQ-012 SHALL have ALU_op  output  4, ALU_op1  output  XLEN, ALU_op2  output  XLEN: drive the shared EX_ALU.
REQ-013 SHALL have ALU_result  input  XLEN: combinational result from EX_ALU.

Function
REQ-014 SHALL keep one result slot per port; slot n is free when r{n}_valid is 0, or when r{n}_valid and r{n}_ready are both 1 in the same cycle.
REQ-015 SHALL treat port n as eligible when p{n}_valid is 1 and slot n is free.
REQ-016 SHALL grant at most one port per cycle: the sole eligible port, or the priority port when both ports are eligible.
REQ-017 SHALL assert p{n}_ready combinationally only for the granted port, and only in the same cycle as the grant.
REQ-018 SHALL drive ALU_op/ALU_op1/ALU_op2 from the granted port's op/a/b; with no grant, it SHALL drive all three to zero.
REQ-019 SHALL capture ALU_result into r{n}_result and set r{n}_valid on the edge ending the grant cycle: 1-cycle latency and aggregate throughput of 1 op per cycle.
REQ-020 SHALL clear r{n}_valid on a cycle with r{n}_ready=1 and no new grant to port n; with a new grant to port n it SHALL keep r{n}_valid=1 and load the new result (back-to-back).
REQ-021 SHALL hold r{n}_result and r{n}_valid stable while r{n}_valid=1 and r{n}_ready=0.
REQ-022 SHALL move priority to the other port after any grant; with no grant, priority SHALL stay unchanged.
REQ-023 SHALL refuse a request to port n while slot n is full and not draining; the other port SHALL still be granted if eligible.
REQ-024 SHALL ignore r{n}_ready when r{n}_valid=0.
REQ-025 SHALL pass op and operands unchanged; it SHALL do no arithmetic or width conversion itself.

Reset
REQ-026 SHALL, while resetn=0, force r0_valid=r1_valid=0, r0_result=r1_result=0 and priority=RESET_PRIO, with p0_ready=p1_ready=0 and ALU outputs zero.
REQ-027 SHALL discard any in-flight or held result on reset mid-operation; it SHALL accept the first grant on the first rising edge after resetn rises.

Verification
REQ-028 SHALL verify single request: p0 op=ADD, a=5, b=7, r0_ready=1 -> p0_ready=1 in the same cycle; next cycle r0_valid=1, r0_result=12; cleared the cycle after.
REQ-029 SHALL verify contention: both ports valid from reset with RESET_PRIO=0 -> grants alternate p0,p1,p0,p1 on consecutive cycles; each port gets one result every 2 cycles.
REQ-030 SHALL verify backpressure: r1_ready=0 after one p1 result=0x10 -> p1_ready stays 0, r1_result stays 0x10; p0 is still granted every cycle.
REQ-031 SHALL verify drain plus refill: r0_valid=1 with r0_ready=1 and p0 requesting a=1, b=2 -> p0_ready=1; next cycle r0_valid=1, r0_result=3.
REQ-032 SHALL verify idle: no valid requests -> ALU_op=0, ALU_op1=0, ALU_op2=0; priority unchanged.
REQ-033 SHALL verify async reset: resetn low mid-cycle with r0_valid=1 -> r0_valid=0 immediately, without waiting for clk; priority returns to RESET_PRIO.

Source files
------------

// File: rtl/ex_alu_arbiter.sv
// ex_alu_arbiter
//   Shares one combinational EX_ALU between two request ports. Each cycle at
//   most one port is granted. The granted port's op/operands drive the ALU,
//   and the ALU result is captured into that port's result slot on the edge
//   that ends the grant cycle. A one-bit round-robin pointer decides which
//   port wins when both are eligible.
//
//   Ports
//     clk, resetn                 clock, async active-low reset
//     p{n}_valid/_ready           request handshake for port n
//     p{n}_op, p{n}_a, p{n}_b     opcode and operands for port n
//     r{n}_valid/_ready           result handshake for port n
//     r{n}_result                 registered result for port n
//     ALU_op, ALU_op1, ALU_op2    drive the shared ALU (zero when idle)
//     ALU_result                  combinational result from the ALU
//
//   Priority state
//     prio | meaning
//     -----+-------------------------------------------
//       0  | port 0 wins when both ports are eligible
//       1  | port 1 wins when both ports are eligible
module ex_alu_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic            clk,
  input  logic            resetn,

  input  logic            p0_valid,
  output logic            p0_ready,
  input  logic [3:0]      p0_op,
  input  logic [XLEN-1:0] p0_a,
  input  logic [XLEN-1:0] p0_b,

  input  logic            p1_valid,
  output logic            p1_ready,
  input  logic [3:0]      p1_op,
  input  logic [XLEN-1:0] p1_a,
  input  logic [XLEN-1:0] p1_b,

  output logic            r0_valid,
  input  logic            r0_ready,
  output logic [XLEN-1:0] r0_result,

  output logic            r1_valid,
  input  logic            r1_ready,
  output logic [XLEN-1:0] r1_result,

  output logic [3:0]      ALU_op,
  output logic [XLEN-1:0] ALU_op1,
  output logic [XLEN-1:0] ALU_op2,
  input  logic [XLEN-1:0] ALU_result
);

  localparam logic PRIO_INIT = (RESET_PRIO != 0);

  logic prio, prio_nxt;
  logic slot0_free, slot1_free;
  logic elig0, elig1;
  logic grant0, grant1;

  // A slot is free when empty or when its result is being consumed this
  // cycle, which allows back-to-back issue to the same port.
  assign slot0_free = !r0_valid || r0_ready;
  assign slot1_free = !r1_valid || r1_ready;

  // Gating with resetn keeps the handshake and ALU outputs quiet while the
  // async reset is asserted, not just after the next edge.
  assign elig0 = resetn && p0_valid && slot0_free;
  assign elig1 = resetn && p1_valid && slot1_free;

  assign grant0 = elig0 && (!elig1 || !prio);
  assign grant1 = elig1 && (!elig0 ||  prio);

  // priority register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prio <= PRIO_INIT;
    else         prio <= prio_nxt;
  end

  // next priority: hand over to the other port after any grant
  always_comb begin
    prio_nxt = prio;
    if (grant0)      prio_nxt = 1'b1;
    else if (grant1) prio_nxt = 1'b0;
  end

  // outputs: handshake and ALU operand mux
  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    ALU_op   = '0;
    ALU_op1  = '0;
    ALU_op2  = '0;
    if (grant0) begin
      p0_ready = 1'b1;
      ALU_op   = p0_op;
      ALU_op1  = p0_a;
      ALU_op2  = p0_b;
    end else if (grant1) begin
      p1_ready = 1'b1;
      ALU_op   = p1_op;
      ALU_op1  = p1_a;
      ALU_op2  = p1_b;
    end
  end

  // result slots; a new grant takes precedence over a drain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r0_valid  <= 1'b0;
      r0_result <= '0;
      r1_valid  <= 1'b0;
      r1_result <= '0;
    end else begin
      if (grant0) begin
        r0_valid  <= 1'b1;
        r0_result <= ALU_result;
      end else if (r0_valid && r0_ready) begin
        r0_valid  <= 1'b0;
      end
      if (grant1) begin
        r1_valid  <= 1'b1;
        r1_result <= ALU_result;
      end else if (r1_valid && r1_ready) begin
        r1_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_arbiter.sv
// Directed bench for ex_alu_arbiter with a small behavioural ALU.
module tb_ex_alu_arbiter;

  localparam int XLEN = 32;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;

  logic            clk = 1'b0;
  logic            resetn;
  logic            p0_valid, p1_valid, p0_ready, p1_ready;
  logic [3:0]      p0_op, p1_op;
  logic [XLEN-1:0] p0_a, p0_b, p1_a, p1_b;
  logic            r0_valid, r1_valid, r0_ready, r1_ready;
  logic [XLEN-1:0] r0_result, r1_result;
  logic [3:0]      ALU_op;
  logic [XLEN-1:0] ALU_op1, ALU_op2, ALU_result;

  int n_cmp = 0;
  int n_err = 0;

  ex_alu_arbiter #(.XLEN(XLEN), .RESET_PRIO(0)) dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_op(p0_op), .p0_a(p0_a), .p0_b(p0_b),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_op(p1_op), .p1_a(p1_a), .p1_b(p1_b),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_result(r0_result),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_result(r1_result),
    .ALU_op(ALU_op), .ALU_op1(ALU_op1), .ALU_op2(ALU_op2), .ALU_result(ALU_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (ALU_op)
      4'h0:    ALU_result = ALU_op1 + ALU_op2;
      4'h1:    ALU_result = ALU_op1 - ALU_op2;
      4'h2:    ALU_result = ALU_op1 & ALU_op2;
      4'h3:    ALU_result = ALU_op1 | ALU_op2;
      default: ALU_result = ALU_op1 ^ ALU_op2;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn   = 1'b0;
    p0_valid = 1'b1; p0_op = OP_ADD; p0_a = 32'd9; p0_b = 32'd9;
    p1_valid = 1'b1; p1_op = OP_ADD; p1_a = 32'd4; p1_b = 32'd4;
    r0_ready = 1'b0; r1_ready = 1'b0;

    // reset state, with requests pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r0_valid",  r0_valid, 0);
    chk("rst_r1_valid",  r1_valid, 0);
    chk("rst_r0_result", r0_result, 0);
    chk("rst_r1_result", r1_result, 0);
    chk("rst_p0_ready",  p0_ready, 0);
    chk("rst_p1_ready",  p1_ready, 0);
    chk("rst_alu_op1",   ALU_op1, 0);

    // single request: first edge after release accepts it
    resetn = 1'b1;
    p1_valid = 1'b0;
    p0_op = OP_ADD; p0_a = 32'd5; p0_b = 32'd7;
    r0_ready = 1'b1; r1_ready = 1'b1;
    #1;
    chk("single_p0_ready", p0_ready, 1);
    chk("single_p1_ready", p1_ready, 0);
    chk("single_alu_op1",  ALU_op1, 5);
    chk("single_alu_op2",  ALU_op2, 7);
    step();
    chk("single_r0_valid",  r0_valid, 1);
    chk("single_r0_result", r0_result, 12);
    p0_valid = 1'b0;
    #1;
    chk("single_p0_ready_off", p0_ready, 0);
    step();
    chk("single_r0_cleared", r0_valid, 0);

    // contention from reset: grants alternate p0,p1,p0,p1
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    p0_valid = 1'b1; p0_op = OP_ADD; p0_a = 32'd1;  p0_b = 32'd2;
    p1_valid = 1'b1; p1_op = OP_SUB; p1_a = 32'd10; p1_b = 32'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont_p0_ready_%0d", i), p0_ready, (i % 2 == 0));
      chk($sformatf("cont_p1_ready_%0d", i), p1_ready, (i % 2 == 1));
      step();
      chk($sformatf("cont_r0_valid_%0d", i), r0_valid, (i % 2 == 0));
      chk($sformatf("cont_r1_valid_%0d", i), r1_valid, (i % 2 == 1));
      if (i % 2 == 0) chk($sformatf("cont_r0_result_%0d", i), r0_result, 3);
      else            chk($sformatf("cont_r1_result_%0d", i), r1_result, 7);
    end

    // backpressure: p1 produces 0x10, then holds while p0 keeps issuing
    p0_valid = 1'b0;
    p1_op = OP_ADD; p1_a = 32'd8; p1_b = 32'd8;
    #1;
    chk("bp_p1_ready_first", p1_ready, 1);
    step();
    chk("bp_r1_valid_first",  r1_valid, 1);
    chk("bp_r1_result_first", r1_result, 32'h10);
    r1_ready = 1'b0;
    p1_a = 32'd1; p1_b = 32'd1;
    p0_valid = 1'b1; p0_op = OP_ADD; p0_b = 32'd100;
    for (int k = 0; k < 3; k++) begin
      p0_a = k;
      #1;
      chk($sformatf("bp_p1_ready_%0d", k), p1_ready, 0);
      chk($sformatf("bp_p0_ready_%0d", k), p0_ready, 1);
      step();
      chk($sformatf("bp_r1_valid_%0d", k),  r1_valid, 1);
      chk($sformatf("bp_r1_result_%0d", k), r1_result, 32'h10);
      chk($sformatf("bp_r0_result_%0d", k), r0_result, 100 + k);
    end

    // drain plus refill on port 0
    p0_a = 32'd1; p0_b = 32'd2;
    #1;
    chk("refill_p0_ready", p0_ready, 1);
    step();
    chk("refill_r0_valid",  r0_valid, 1);
    chk("refill_r0_result", r0_result, 3);

    // idle: ALU outputs zero, priority (now port 1) held
    p0_valid = 1'b0; p1_valid = 1'b0;
    r1_ready = 1'b1;
    #1;
    chk("idle_alu_op",  ALU_op, 0);
    chk("idle_alu_op1", ALU_op1, 0);
    chk("idle_alu_op2", ALU_op2, 0);
    step();
    step();
    chk("idle_r0_valid", r0_valid, 0);
    chk("idle_r1_valid", r1_valid, 0);
    p0_valid = 1'b1; p0_a = 32'd2; p0_b = 32'd2;
    p1_valid = 1'b1; p1_a = 32'd3; p1_b = 32'd3;
    #1;
    chk("idle_prio_p1_ready", p1_ready, 1);
    chk("idle_prio_p0_ready", p0_ready, 0);
    step();
    chk("idle_r1_result", r1_result, 6);

    // async reset with a held result and priority on port 1
    p1_valid = 1'b0;
    r0_ready = 1'b0;
    #1;
    chk("ar_p0_ready", p0_ready, 1);
    step();
    chk("ar_r0_valid_before",  r0_valid, 1);
    chk("ar_r0_result_before", r0_result, 4);
    p0_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_r0_valid_async",  r0_valid, 0);
    chk("ar_r0_result_async", r0_result, 0);
    resetn = 1'b1;
    p0_valid = 1'b1; p1_valid = 1'b1;
    r0_ready = 1'b1;
    #1;
    chk("ar_prio_p0_ready", p0_ready, 1);
    chk("ar_prio_p1_ready", p1_ready, 0);
    step();
    chk("ar_r0_result_after", r0_result, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
